// File: rtl/backend_pkg.sv
// Shared types for the decoder-to-backend micro-op path.
//   UOP_W       : width of the uop encoding field (128 encodings)
//   AREG_W      : width of an architectural register index (16 registers)
//   IMM_W       : immediate width
//   uop_entry_t : one buffered micro-op, in the field order the backend consumes
package backend_pkg;

  localparam int unsigned UOP_W  = $clog2(128);
  localparam int unsigned AREG_W = $clog2(16);
  localparam int unsigned IMM_W  = 32;

  typedef struct packed {
    logic [UOP_W-1:0]  uop;
    logic              eoi;
    logic [IMM_W-1:0]  imm;
    logic              use_imm;
    logic [31:0]       pc;
    logic              except;
    logic [AREG_W-1:0] src1_arch;
    logic [AREG_W-1:0] src2_arch;
    logic [AREG_W-1:0] dest_arch;
  } uop_entry_t;

endpackage

// File: rtl/uop_fifo_mem.sv
// Storage array for uop_queue: DEPTH entries of uop_entry_t.
// One synchronous write port, one asynchronous read port, no reset.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : entry to write
//   raddr : read index
//   rdata : entry at raddr (combinational)
import backend_pkg::*;

module uop_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  uop_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output uop_entry_t    rdata
);

  uop_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uop_queue.sv
// Decoupling FIFO between the decoder and the backend.
// Accepts decoded uops on a valid/ready handshake, buffers up to DEPTH
// entries and presents the head entry to the backend, which pops with
// be_ready. flush discards everything at the next edge.
//   clk, rst (async, active-low), flush
//   dec_valid/dec_ready + dec_* : incoming entry
//   be_ready                    : backend pops the head
//   uop_ready + head fields     : head entry (fields zero while empty)
//   count                       : occupancy 0..DEPTH
//   insn_count                  : buffered entries with eoi set
import backend_pkg::*;

module uop_queue #(
  parameter int unsigned NUM_UOPS      = 128,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ARCHFILE_SIZE = 16,
  parameter int unsigned DEPTH         = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             dec_valid,
  output logic                             dec_ready,
  input  logic [$clog2(NUM_UOPS)-1:0]      dec_uop,
  input  logic                             dec_eoi,
  input  logic [XLEN-1:0]                  dec_imm,
  input  logic                             dec_use_imm,
  input  logic [31:0]                      dec_pc,
  input  logic                             dec_except,
  input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_src1_arch,
  input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_src2_arch,
  input  logic [$clog2(ARCHFILE_SIZE)-1:0] dec_dest_arch,
  input  logic                             be_ready,
  output logic                             uop_ready,
  output logic [$clog2(NUM_UOPS)-1:0]      uop,
  output logic                             eoi,
  output logic [XLEN-1:0]                  imm,
  output logic                             use_imm,
  output logic [31:0]                      pc,
  output logic                             except,
  output logic [$clog2(ARCHFILE_SIZE)-1:0] src1_arch,
  output logic [$clog2(ARCHFILE_SIZE)-1:0] src2_arch,
  output logic [$clog2(ARCHFILE_SIZE)-1:0] dest_arch,
  output logic [$clog2(DEPTH):0]           count,
  output logic [$clog2(DEPTH):0]           insn_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, insn_q;
  logic          push, pop;
  uop_entry_t    wr_entry, rd_entry, head_entry;

  always_comb begin
    wr_entry           = '0;
    wr_entry.uop       = dec_uop;
    wr_entry.eoi       = dec_eoi;
    wr_entry.imm       = dec_imm;
    wr_entry.use_imm   = dec_use_imm;
    wr_entry.pc        = dec_pc;
    wr_entry.except    = dec_except;
    wr_entry.src1_arch = dec_src1_arch;
    wr_entry.src2_arch = dec_src2_arch;
    wr_entry.dest_arch = dec_dest_arch;
  end

  // dec_ready deliberately ignores be_ready: a full queue never accepts,
  // even when the head is popped in the same cycle.
  assign dec_ready = (count_q != CW'(DEPTH)) && !flush;
  assign uop_ready = (count_q != '0);
  assign push      = dec_valid && dec_ready;
  assign pop       = uop_ready && be_ready && !flush;

  uop_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      insn_q  <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      insn_q  <= '0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      insn_q  <= insn_q + CW'(push && dec_eoi) - CW'(pop && rd_entry.eoi);
    end
  end

  // Storage is not reset, so stale contents are masked while empty.
  assign head_entry = uop_ready ? rd_entry : '0;

  assign uop        = head_entry.uop;
  assign eoi        = head_entry.eoi;
  assign imm        = head_entry.imm;
  assign use_imm    = head_entry.use_imm;
  assign pc         = head_entry.pc;
  assign except     = head_entry.except;
  assign src1_arch  = head_entry.src1_arch;
  assign src2_arch  = head_entry.src2_arch;
  assign dest_arch  = head_entry.dest_arch;
  assign count      = count_q;
  assign insn_count = insn_q;

endmodule

// File: tb/tb_uop_queue.sv
// Self-checking bench for uop_queue: directed scenarios plus randomized
// traffic, checked against a queue-based reference of the buffer contents.
import backend_pkg::*;

module tb_uop_queue;

  logic        clk = 1'b0;
  logic        rst, flush, dec_valid, dec_ready, be_ready, uop_ready;
  logic [6:0]  dec_uop, uop;
  logic        dec_eoi, eoi, dec_use_imm, use_imm, dec_except, except;
  logic [31:0] dec_imm, imm, dec_pc, pc;
  logic [3:0]  dec_src1_arch, dec_src2_arch, dec_dest_arch;
  logic [3:0]  src1_arch, src2_arch, dest_arch;
  logic [3:0]  count, insn_count;

  int unsigned tests = 0;
  int unsigned fails = 0;

  uop_entry_t sb[$];   // expected buffer contents, oldest first

  uop_queue #(.NUM_UOPS(128), .XLEN(32), .ARCHFILE_SIZE(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_uop(dec_uop), .dec_eoi(dec_eoi), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .dec_pc(dec_pc), .dec_except(dec_except),
    .dec_src1_arch(dec_src1_arch), .dec_src2_arch(dec_src2_arch),
    .dec_dest_arch(dec_dest_arch),
    .be_ready(be_ready), .uop_ready(uop_ready),
    .uop(uop), .eoi(eoi), .imm(imm), .use_imm(use_imm), .pc(pc),
    .except(except), .src1_arch(src1_arch), .src2_arch(src2_arch),
    .dest_arch(dest_arch), .count(count), .insn_count(insn_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic uop_entry_t rnd_entry(input logic [31:0] p);
    uop_entry_t e;
    e.uop       = 7'($urandom());
    e.eoi       = 1'($urandom());
    e.imm       = $urandom();
    e.use_imm   = 1'($urandom());
    e.pc        = p;
    e.except    = 1'($urandom());
    e.src1_arch = 4'($urandom());
    e.src2_arch = 4'($urandom());
    e.dest_arch = 4'($urandom());
    return e;
  endfunction

  // One cycle of stimulus, starting and ending at a falling edge.
  // The reference is updated only after the edge so the monitor always
  // sees it matching the DUT's current contents.
  task automatic step(input bit v, input uop_entry_t e, input bit b, input bit f);
    bit acc;
    dec_valid     = v;
    dec_uop       = e.uop;
    dec_eoi       = e.eoi;
    dec_imm       = e.imm;
    dec_use_imm   = e.use_imm;
    dec_pc        = e.pc;
    dec_except    = e.except;
    dec_src1_arch = e.src1_arch;
    dec_src2_arch = e.src2_arch;
    dec_dest_arch = e.dest_arch;
    be_ready      = b;
    flush         = f;
    acc = v && !f && rst && (sb.size() != 8);
    @(posedge clk);
    #1;
    if (f) sb.delete();
    else if (acc) sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input bit b);
    step(1'b0, '0, b, 1'b0);
  endtask

  // Monitor: compares occupancy, handshake and head fields every cycle and
  // retires the expected head whenever the backend takes it.
  initial begin
    uop_entry_t obs, exp_head;
    int unsigned n, ne;
    forever begin
      @(negedge clk);
      #3;
      n  = sb.size();
      ne = 0;
      foreach (sb[i]) if (sb[i].eoi) ne++;
      obs = '{uop, eoi, imm, use_imm, pc, except, src1_arch, src2_arch, dest_arch};
      exp_head = (n != 0) ? sb[0] : '0;
      chk("count", 128'(count), 128'(n));
      chk("insn_count", 128'(insn_count), 128'(ne));
      chk("uop_ready", 128'(uop_ready), 128'(n != 0));
      chk("dec_ready", 128'(dec_ready), 128'((n != 8) && !flush));
      chk("head", 128'(obs), 128'(exp_head));
      if (rst && be_ready && !flush && n != 0) void'(sb.pop_front());
    end
  end

  initial begin
    uop_entry_t e;
    bit b;
    rst = 1'b0; flush = 1'b0; dec_valid = 1'b1; be_ready = 1'b0;
    dec_uop = '0; dec_eoi = 1'b0; dec_imm = '0; dec_use_imm = 1'b0;
    dec_pc = '0; dec_except = 1'b0;
    dec_src1_arch = '0; dec_src2_arch = '0; dec_dest_arch = '0;

    // reset held with dec_valid high: nothing may be accepted
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // single push, visible the following cycle
    e = '0; e.uop = 7'd5; e.imm = 32'h1111_1111; e.pc = 32'd0; e.eoi = 1'b1;
    step(1'b1, e, 1'b0, 1'b0);
    chk("first_uop", 128'(uop), 128'(5));
    idle(1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // fill to 8, ninth offer refused, then drain in order
    for (int i = 0; i < 8; i++) step(1'b1, rnd_entry(32'(i)), 1'b0, 1'b0);
    chk("full_count", 128'(count), 128'(8));
    step(1'b1, rnd_entry(32'd99), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);
    chk("drained_pc", 128'(pc), 128'(0));

    // streaming through the pointer wrap
    for (int i = 0; i < 20; i++) step(1'b1, rnd_entry(32'(100 + i)), 1'b1, 1'b0);
    chk("stream_count", 128'(count), 128'(1));
    idle(1'b1);

    // flush a full queue while pushing and popping
    for (int i = 0; i < 8; i++) begin
      e = rnd_entry(32'(200 + i));
      e.eoi = (i < 3);
      step(1'b1, e, 1'b0, 1'b0);
    end
    chk("pre_flush_insn", 128'(insn_count), 128'(3));
    step(1'b1, rnd_entry(32'd300), 1'b1, 1'b1);
    chk("post_flush_count", 128'(count), 128'(0));
    idle(1'b0);

    // asynchronous reset mid-cycle with 5 entries buffered
    for (int i = 0; i < 5; i++) step(1'b1, rnd_entry(32'(400 + i)), 1'b0, 1'b0);
    dec_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("async_uop_ready", 128'(uop_ready), 128'(0));
    chk("async_count", 128'(count), 128'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    e = rnd_entry(32'h500);
    step(1'b1, e, 1'b0, 1'b0);
    chk("post_reset_pc", 128'(pc), 128'(32'h500));

    // except/use_imm pass through untouched
    e = rnd_entry(32'h600); e.except = 1'b1; e.use_imm = 1'b1;
    step(1'b1, e, 1'b1, 1'b0);
    chk("except_field", 128'(except), 128'(1));
    chk("use_imm_field", 128'(use_imm), 128'(1));
    idle(1'b1);

    // randomized traffic with phases biased toward full and toward empty
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) b = ($urandom_range(0, 3) == 0);
      else                   b = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 3) != 0), rnd_entry(32'(1000 + i)), b,
           ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 10; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uop_queue.md
# uop_queue

Decoupling FIFO directly upstream of `backend_TOP`. It accepts decoded micro-ops from the decoder with a valid/ready handshake, buffers up to `DEPTH` entries, and presents the head entry on exactly the field set `backend_TOP` consumes: `uop_ready`, `uop`, `eoi`, `imm`, `use_imm`, `pc`, `except`, `src1_arch`, `src2_arch`, `dest_arch`. The backend pops the head with `be_ready`, and a synchronous `flush` discards all buffered uops on a redirect.

## Interface
- `NUM_UOPS`, 128, number of uop encodings; uop field width is $clog2(NUM_UOPS).
- `XLEN`, 32, immediate width.
- `ARCHFILE_SIZE`, 16, architectural registers; register field width is $clog2(ARCHFILE_SIZE).
- `DEPTH`, 8, queue entries; must be a power of two and at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (already decided).
- `flush`  in  1  synchronous discard of all entries.
- `dec_valid`  in  1  decoder offers an entry.
- `dec_ready`  out  1  queue can accept an entry this cycle.
- `dec_uop`, `dec_eoi`, `dec_imm`, `dec_use_imm`, `dec_pc`, `dec_except`, `dec_src1_arch`, `dec_src2_arch`, `dec_dest_arch`  in  $clog2(NUM_UOPS)/1/XLEN/1/32/1/$clog2(ARCHFILE_SIZE)×3  fields of the offered entry.
- `be_ready`  in  1  backend accepts the head entry this cycle.
- `uop_ready`  out  1  head entry is valid.
- `uop`, `eoi`, `imm`, `use_imm`, `pc`, `except`, `src1_arch`, `src2_arch`, `dest_arch`  out  same widths as the `dec_*` inputs  head entry fields.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `insn_count`  out  $clog2(DEPTH)+1  number of buffered entries with `eoi`=1.

## Operation
- Storage: a circular buffer with `head` and `tail` pointers of width $clog2(DEPTH). Pointers wrap naturally modulo `DEPTH`.
- Push: occurs when `dec_valid && dec_ready && !flush`. The entry is written at `tail`, `tail` increments, and `count` increments.
- `dec_ready` = (`count` != DEPTH) && !`flush`. It is purely combinational and has no dependence on `be_ready`; a full queue does not accept a push even when a pop happens in the same cycle.
- Pop: occurs when `uop_ready && be_ready && !flush`. `head` increments and `count` decrements.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `uop_ready` = (`count` != 0). While the queue is empty, every head field output is forced to 0.
- `insn_count`: +1 on a push with `dec_eoi`=1, −1 on a pop with head `eoi`=1, net change when both happen in the same cycle.
- Flush: at the next edge, `count`, `insn_count`, `head` and `tail` all clear to 0. Any push or pop in that cycle is ignored. Flush takes priority over all other events.
- `except` is carried as a data field only. The queue does not act on it.
- Reset (asynchronous, `rst`=0): pointers and counters clear immediately, including mid-operation. Storage contents are not reset.
- Output values while in reset: `uop_ready`=0, all head fields 0, `count`=0, `insn_count`=0, `dec_ready`=1 unless `flush` is asserted.

## Timing
- Latency: an entry pushed at edge N appears on the head outputs with `uop_ready`=1 in the cycle after edge N. There is no same-cycle bypass from `dec_*` to the outputs.
- Pop: the next entry is visible in the cycle after the popping edge.
- Head outputs are combinational reads of registered storage.
- Throughput: one push and one pop per cycle when the queue is neither full nor empty.

## Structure
- Package `backend_pkg`:
  - field-width localparams: `UOP_W`, `AREG_W`;
  - packed struct `uop_entry_t` {uop, eoi, imm, use_imm, pc, except, src1_arch, src2_arch, dest_arch}.
- Sub-module `uop_fifo_mem`: `DEPTH` × `uop_entry_t` register array with one write port and one asynchronous read port, no reset. `uop_queue` holds the pointers, counters and handshake logic.

## Test plan
- Reset with `dec_valid`=1, then release. Push one entry {uop=5, imm=32'h1111_1111, pc=0, eoi=1} with `be_ready`=0. Next cycle: `uop_ready`=1, `uop`=5, `count`=1, `insn_count`=1.
- Push 8 entries (pc 0..7) with `be_ready`=0. Then `count`=8 and `dec_ready`=0, and a 9th offer is not accepted. Set `be_ready`=1. Outputs pop in pc order 0..7, then `uop_ready`=0 and all head fields are 0.
- Hold `dec_valid`=1 and `be_ready`=1 continuously for 20 cycles from empty. `count` stays at 1 in steady state. pc values stream in order, including the pointer wrap after 8.
- Full queue (8 entries, 3 with eoi=1); assert `flush` together with `dec_valid`=1 and `be_ready`=1. Next cycle: `count`=0, `insn_count`=0, `uop_ready`=0, no entry accepted or popped.
- Drop `rst` asynchronously mid-cycle with 5 entries buffered. `uop_ready` falls before the next edge. After release, the first push appears at the head with no stale data.
- Push an entry with `except`=1 and `use_imm`=1. Both fields appear unchanged on the head outputs.
